// File: rtl/fir_mac_accum_pkg.sv
// fir_mac_accum_pkg: shared ANC datapath widths, width helpers and MAC state encoding
package fir_mac_accum_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int COEF_W_DEF = 16;
    typedef enum logic [1:0] {ACCUM, DRAIN, PRESENT} mac_state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + clog2(ntaps);
    endfunction
endpackage

// File: rtl/fir_mul_reg.sv
// fir_mul_reg: registered signed multiplier, product sign-extended to the accumulator width
module fir_mul_reg #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  prod,
    output logic                     vld
);
    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
            vld  <= 1'b0;
        end else begin
            vld <= en;
            if (en) prod <= ACC_W'(a) * ACC_W'(b);
        end
    end
endmodule

// File: rtl/fir_mac_accum.sv
// fir_mac_accum: streaming signed MAC summing one NTAPS frame into a guard-extended result
module fir_mac_accum
    import fir_mac_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int NTAPS  = 32,
    parameter int OUT_W  = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic signed [DATA_W-1:0]                        in_sample,
    input  logic signed [COEF_W-1:0]                        in_coef,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic signed [acc_width(DATA_W, COEF_W, NTAPS)-1:0] out_sum,
    output logic                                            out_clip
);
    localparam int GUARD_W = clog2(NTAPS);
    localparam int ACC_W   = acc_width(DATA_W, COEF_W, NTAPS);
    mac_state_t state, state_nx;
    logic [GUARD_W-1:0] cnt;
    logic signed [ACC_W-1:0] acc, prod;
    logic [ACC_W-OUT_W:0] top;
    logic prod_vld, take, last, done;
    fir_mul_reg #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .en   (take),
        .a    (in_sample),
        .b    (in_coef),
        .prod (prod),
        .vld  (prod_vld)
    );
    assign take = in_valid && in_ready;
    assign last = cnt == GUARD_W'(NTAPS - 1);
    assign done = state == PRESENT && out_ready;
    always_comb begin
        state_nx = (state == ACCUM && take && last) ? DRAIN :
                   (state == DRAIN)                 ? PRESENT :
                   done                             ? ACCUM : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= state_nx == ACCUM;
            out_valid <= state_nx == PRESENT;
            if (take) cnt <= last ? '0 : cnt + GUARD_W'(1);
            acc <= done ? '0 : prod_vld ? acc + prod : acc;
        end
    end
    // clip when the bits above the OUT_W sign position are not a pure sign extension
    assign top      = acc[ACC_W-1:OUT_W-1];
    assign out_sum  = out_valid ? acc : '0;
    assign out_clip = out_valid && !(&top || ~|top);
endmodule

// File: tb/tb_fir_mac_accum.sv
// tb_fir_mac_accum: directed and randomized frames checked against an arithmetic frame-sum model
module tb_fir_mac_accum;
    localparam int NT = 4;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_clip;
    logic signed [15:0] in_sample = '0, in_coef = '0;
    logic signed [33:0] out_sum;
    longint sa[NT], ca[NT];
    int vectors = 0, errs = 0;
    always #5 clk = ~clk;
    fir_mac_accum #(.DATA_W(16), .COEF_W(16), .NTAPS(NT), .OUT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_clip  (out_clip)
    );
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic longint clips(input longint v);
        return (v > 32767 || v < -32768) ? 1 : 0;
    endfunction
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, in_ready, 1);
    endtask
    task automatic run_frame(input string tag, input int gap, input int stall);
        longint exp = 0;
        for (int i = 0; i < NT; i++) exp += sa[i] * ca[i];
        for (int i = 0; i < NT; i++) begin
            wait_ready(tag);
            in_valid = 1'b1; in_sample = 16'(sa[i]); in_coef = 16'(ca[i]);
            @(negedge clk);
            in_valid = 1'b0;
            for (int g = 0; g < gap && i < NT - 1; g++) begin
                chk({tag, "_gap_ready"}, in_ready, 1);
                chk({tag, "_gap_valid"}, out_valid, 0);
                @(negedge clk);
            end
        end
        chk({tag, "_drain_valid"}, out_valid, 0);
        chk({tag, "_drain_ready"}, in_ready, 0);
        out_ready = (stall == 0);
        if (stall > 0) begin
            in_valid = 1'b1; in_sample = 16'($urandom); in_coef = 16'($urandom);
        end
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, exp);
        chk({tag, "_clip"}, out_clip, clips(exp));
        for (int k = 0; k < stall; k++) begin
            in_sample = 16'($urandom); in_coef = 16'($urandom);
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_sum"}, out_sum, exp);
            chk({tag, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_after_valid"}, out_valid, 0);
        chk({tag, "_after_ready"}, in_ready, 1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_clip", out_clip, 0);
        rst = 1'b0;
        sa = '{1, 2, -4, 100}; ca = '{1, 3, 5, 100};
        run_frame("basic", 0, 0);
        sa = '{-32768, -32768, -32768, -32768}; ca = '{-32768, -32768, -32768, -32768};
        run_frame("minmin", 0, 0);
        sa = '{1000, 1000, 0, -1}; ca = '{40, -7, 5, -1};
        run_frame("gaps", 3, 0);
        sa = '{300, -5, 12, 9}; ca = '{-3, 77, 1, 8};
        run_frame("stall", 0, 5);
        sa = '{1, 1, 1, 1}; ca = '{1, 1, 1, 1};
        run_frame("after_stall", 0, 0);
        sa = '{32767, 0, 0, 0}; ca = '{1, 0, 0, 0};
        run_frame("edge_max", 0, 0);
        sa = '{-32768, 0, 0, 0}; ca = '{1, 0, 0, 0};
        run_frame("edge_min", 0, 0);
        sa = '{32767, 1, 0, 0}; ca = '{1, 1, 0, 0};
        run_frame("edge_over", 0, 0);
        sa = '{-32768, -1, 0, 0}; ca = '{1, 1, 0, 0};
        run_frame("edge_under", 0, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_sample = 16'sd7; in_coef = 16'sd9;
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", out_sum, 0);
        rst = 1'b0;
        sa = '{2, 2, 2, 2}; ca = '{2, 2, 2, 2};
        run_frame("post_rst", 0, 0);
        for (int i = 0; i < NT; i++) begin
            in_valid = 1'b1; in_sample = 16'sd5; in_coef = 16'sd5;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("prst_valid", out_valid, 1);
        chk("prst_sum", out_sum, 100);
        rst = 1'b1;
        @(negedge clk);
        chk("prst_drop_valid", out_valid, 0);
        chk("prst_drop_sum", out_sum, 0);
        chk("prst_drop_ready", in_ready, 1);
        rst = 1'b0; out_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            for (int k = 0; k < NT; k++) begin
                sa[k] = longint'($signed(16'($urandom)));
                ca[k] = longint'($signed(16'($urandom)));
                if ($urandom_range(3) == 0) sa[k] = -32768;
                if ($urandom_range(7) == 0) ca[k] = $urandom_range(1) ? -32768 : 32767;
                if (f % 4 == 3) begin
                    sa[k] = sa[k] % 200;
                    ca[k] = ca[k] % 40;
                end
            end
            run_frame("rand", int'($urandom_range(2)), int'($urandom_range(2)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
